fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the pipeline front end and the single-cycle, registered-read instruction memory. Owns the program counter and drives the memory's address and flush inputs. Tracks the one in-flight read and buffers returned words in a small FIFO. Presents them to decode over a valid/ready handshake and squashes wrong-path words on a taken branch.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_ctrl.sv | 92 +++++++++
 tb/tb_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: buffered fetch entries
// and the fetch FSM encoding.
package h2bp;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs for decode.
// Synchronous clear discards all entries; push and pop may coincide when full.
module fetch_fifo
    import h2bp::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t      mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, tracks the single in-flight memory read and
// hands buffered words to decode, squashing wrong-path words on a redirect.
module fetch_ctrl
    import h2bp::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_pc,
    output logic        imem_flush,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   inflight_pc_q;
    logic          inflight_q;
    fetch_state_t  state_q;

    logic [CW-1:0] count_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_data_s;
    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [CW:0]   occ_s;

    // Handshake and issue decision; occupancy counts words already owed to the FIFO.
    always_comb begin
        if_valid = (count_s != {CW{1'b0}}) && !branch_taken;
        pop_s    = if_valid && if_ready;
        push_s   = inflight_q && !branch_taken;
        occ_s    = {1'b0, count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
        issue_s  = !branch_taken && (state_q != BOOT) && (occ_s < DEPTH_W);
    end

    assign push_data_s = '{pc: inflight_pc_q, instr: imem_instr};
    assign imem_pc     = pc_q;
    assign imem_flush  = branch_taken;
    assign if_instr    = head_s.instr;
    assign if_pc       = head_s.pc;

    // PC, in-flight tracking and FSM; BOOT skips the memory's reset-forced zero word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'd0;
            inflight_q    <= 1'b0;
            state_q       <= BOOT;
        end else if (branch_taken) begin
            pc_q       <= branch_target;
            inflight_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            inflight_q <= issue_s;
            if (issue_s) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd1;
            end
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= issue_s ? RUN : HOLD;
                HOLD:    state_q <= issue_s ? RUN : HOLD;
                default: state_q <= BOOT;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (branch_taken),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .count     (count_s),
        .head      (head_s)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations followed by randomized ready/branch/reset traffic.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_pc;
    logic        imem_flush;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since the stream (re)started and next word index owed to decode.
    int          k = 0;
    logic [31:0] exp_next = 32'd0;
    bit          started = 1'b0;
    bit          rst_seen = 1'b0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_pc       (imem_pc),
        .imem_flush    (imem_flush),
        .imem_instr    (imem_instr),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    // Registered-read instruction memory: word = 0xA000_0000 | address.
    always @(posedge clk) begin
        if (rst || imem_flush) imem_instr <= 32'd0;
        else                   imem_instr <= 32'hA000_0000 | imem_pc;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words arrive 3 cycles after a (re)start, in order, and
    // the fetch window (PC ahead of head) grows to DEPTH and stays there.
    always @(negedge clk) begin
        check32("flush", {31'd0, imem_flush}, {31'd0, branch_taken});
        if (rst) begin
            if (rst_seen) begin
                check32("rst_valid", {31'd0, if_valid}, 32'd0);
                check32("rst_pc", imem_pc, RESET_PC);
            end
            rst_seen = 1'b1;
            started  = 1'b1;
            k        = 0;
            exp_next = RESET_PC;
        end else begin
            rst_seen = 1'b0;
            if (started) begin
                if (branch_taken) begin
                    check32("br_valid", {31'd0, if_valid}, 32'd0);
                    exp_next = branch_target;
                    k        = 1;
                end else begin
                    int ed;
                    ed = (k <= 1) ? 0 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
                    check32("valid", {31'd0, if_valid}, (k >= 3) ? 32'd1 : 32'd0);
                    check32("window", imem_pc - exp_next, 32'(ed));
                    if (if_valid && if_ready) begin
                        check32("if_pc", if_pc, exp_next);
                        check32("if_instr", if_instr, 32'hA000_0000 | exp_next);
                        exp_next = exp_next + 32'd1;
                    end
                    if (k < 8) k++;
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        if_ready      = 1'b0;
        repeat (3) next_cyc();
        rst = 1'b0;                          // cycle 0
        repeat (3) next_cyc();               // cycle 3
        @(negedge clk);
        check32("lit_first_valid", {31'd0, if_valid}, 32'd1);
        check32("lit_first_pc", if_pc, 32'd0);
        check32("lit_first_instr", if_instr, 32'hA000_0000);
        repeat (9) next_cyc();               // cycle 12, still stalled
        @(negedge clk);
        check32("lit_stall_head", if_pc, 32'd0);
        check32("lit_stall_imem", imem_pc, 32'd2);
        next_cyc();
        if_ready = 1'b1;
        @(negedge clk);
        check32("lit_resume0", if_pc, 32'd0);
        next_cyc();
        @(negedge clk);
        check32("lit_resume1", if_pc, 32'd1);
        next_cyc();
        @(negedge clk);
        check32("lit_resume2", if_pc, 32'd2);

        // Buffer words 3,4 then redirect to 9 while decode is ready.
        next_cyc();
        if_ready = 1'b0;
        next_cyc();
        if_ready      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'd9;
        @(negedge clk);
        check32("lit_br_valid", {31'd0, if_valid}, 32'd0);
        next_cyc();
        branch_taken = 1'b0;
        repeat (2) next_cyc();
        @(negedge clk);
        check32("lit_br_target", if_pc, 32'd9);
        next_cyc();
        @(negedge clk);
        check32("lit_br_next", if_pc, 32'd10);

        // Back-to-back redirects: only the second target survives.
        next_cyc();
        branch_taken  = 1'b1;
        branch_target = 32'd5;
        next_cyc();
        branch_target = 32'd20;
        next_cyc();
        branch_taken = 1'b0;
        repeat (2) next_cyc();
        @(negedge clk);
        check32("lit_b2b_pc", if_pc, 32'd20);

        // Reset with words buffered.
        next_cyc();
        if_ready = 1'b0;
        repeat (3) next_cyc();
        rst = 1'b1;
        next_cyc();
        rst      = 1'b0;
        if_ready = 1'b1;
        @(negedge clk);
        check32("lit_rst_valid", {31'd0, if_valid}, 32'd0);
        repeat (3) next_cyc();
        @(negedge clk);
        check32("lit_rst_restart", if_pc, RESET_PC);

        // PC wrap from 0xFFFFFFFF to 0.
        next_cyc();
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        next_cyc();
        branch_taken = 1'b0;
        repeat (2) next_cyc();
        @(negedge clk);
        check32("lit_wrap_last", if_pc, 32'hFFFF_FFFF);
        next_cyc();
        @(negedge clk);
        check32("lit_wrap_zero", if_pc, 32'd0);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            next_cyc();
            rst          = ($urandom_range(0, 199) == 0);
            branch_taken = !rst && ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       branch_target = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
                1:       branch_target = $urandom;
                default: branch_target = 32'($urandom_range(0, 63));
            endcase
            if_ready = ($urandom_range(0, 3) != 0);
        end
        next_cyc();
        rst          = 1'b0;
        branch_taken = 1'b0;
        if_ready     = 1'b1;
        repeat (6) next_cyc();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
